// File: rtl/state_pkg.sv
`default_nettype none
// ============================================================================
// Module      : state_pkg
// Description : Sprite pose and jump-phase enumerations plus pose helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package state_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RIGHT1 = 3'd1,
        RIGHT2 = 3'd2,
        LEFT1  = 3'd3,
        LEFT2  = 3'd4
    } state_t;

    typedef enum logic [0:0] {
        GROUND = 1'b0,
        AIR    = 1'b1
    } jump_t;

    // Swap walk phase 1 <-> 2 while keeping the facing direction.
    function automatic state_t toggle_phase(input state_t s);
        case (s)
            RIGHT1:  return RIGHT2;
            RIGHT2:  return RIGHT1;
            LEFT1:   return LEFT2;
            LEFT2:   return LEFT1;
            default: return IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Screen geometry and default player-2 motion constants.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_screen_w         = 1024;
    localparam int c_sprite_w         = 40;
    localparam int c_pos_w            = 12;
    localparam int c_vy_w             = 8;

    localparam int c_p2_x_init        = 600;
    localparam int c_p2_x_max         = c_screen_w - c_sprite_w;
    localparam int c_p2_step          = 4;
    localparam int c_p2_anim_frames   = 8;
    localparam int c_p2_jump_v0       = 12;

endpackage
`default_nettype wire

// File: rtl/player_btn_sync.sv
`default_nettype none
// ============================================================================
// Module      : player_btn_sync
// Description : Two-flop synchronizer for an asynchronous button level with
//               a one-cycle rising-edge pulse on the synchronized signal.
// Revision    : 1.0 - initial release
// ============================================================================
module player_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/player2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player2_ctrl
// Description : Player-2 sprite controller: frame-paced horizontal walking
//               with wall clamping and two-phase pose animation, plus an
//               optional ballistic jump.
//               Optional feature macro: PLAYER2_JUMP_EN (jump logic present
//               when defined; otherwise ypos_player2 is constant 0).
// Revision    : 1.0 - initial release
// ============================================================================
module player2_ctrl
    import vga_pkg::*;
    import state_pkg::*;
#(
    parameter int X_INIT      = c_p2_x_init,
    parameter int X_MAX       = c_p2_x_max,
    parameter int STEP        = c_p2_step,
    parameter int ANIM_FRAMES = c_p2_anim_frames,
    parameter int JUMP_V0     = c_p2_jump_v0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] xpos_player2,
    output logic [11:0] ypos_player2,
    output state_t      state
);

    localparam int            c_anim_w    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [c_anim_w-1:0] c_anim_last = c_anim_w'(ANIM_FRAMES - 1);
    localparam logic [11:0]   c_x_init    = 12'(X_INIT);
    localparam logic [11:0]   c_x_max     = 12'(X_MAX);
    localparam logic [11:0]   c_x_hi      = 12'(X_MAX - STEP);
    localparam logic [11:0]   c_step      = 12'(STEP);

    logic                w_left_lvl;
    logic                w_right_lvl;
    logic                w_left_rise_unused;
    logic                w_right_rise_unused;
    logic                w_go_left;
    logic                w_go_right;

    logic [11:0]         r_x;
    state_t              r_state;
    logic [c_anim_w-1:0] r_anim;

    player_btn_sync u_sync_left (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_left),
        .level (w_left_lvl),
        .rise  (w_left_rise_unused)
    );

    player_btn_sync u_sync_right (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_right),
        .level (w_right_lvl),
        .rise  (w_right_rise_unused)
    );

    // Opposing buttons cancel out to standing still.
    assign w_go_left  = w_left_lvl  & ~w_right_lvl;
    assign w_go_right = w_right_lvl & ~w_left_lvl;

    // Horizontal position, pose and walk animation, advanced once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= c_x_init;
            r_state <= IDLE;
            r_anim  <= '0;
        end else if (frame_tick) begin
            if (w_go_right) begin
                r_x <= (r_x >= c_x_hi) ? c_x_max : r_x + c_step;
                if (r_state == RIGHT1 || r_state == RIGHT2) begin
                    if (r_anim == c_anim_last) begin
                        r_anim  <= '0;
                        r_state <= toggle_phase(r_state);
                    end else begin
                        r_anim <= r_anim + 1'b1;
                    end
                end else begin
                    r_state <= RIGHT1;
                    r_anim  <= '0;
                end
            end else if (w_go_left) begin
                r_x <= (r_x < c_step) ? 12'd0 : r_x - c_step;
                if (r_state == LEFT1 || r_state == LEFT2) begin
                    if (r_anim == c_anim_last) begin
                        r_anim  <= '0;
                        r_state <= toggle_phase(r_state);
                    end else begin
                        r_anim <= r_anim + 1'b1;
                    end
                end else begin
                    r_state <= LEFT1;
                    r_anim  <= '0;
                end
            end else begin
                r_state <= IDLE;
                r_anim  <= '0;
            end
        end
    end

    assign xpos_player2 = r_x;
    assign state        = r_state;

`ifdef PLAYER2_JUMP_EN
    localparam logic signed [11:0] c_y_takeoff  = 12'(-JUMP_V0);
    localparam logic signed [7:0]  c_vy_takeoff = 8'(1 - JUMP_V0);

    logic                w_jump_lvl_unused;
    logic                w_jump_rise;
    logic                w_jump_go;
    logic                r_jump_req;
    jump_t               r_jump;
    logic signed [11:0]  r_y;
    logic signed [7:0]   r_vy;
    logic signed [7:0]   w_vy_grav;
    logic signed [12:0]  w_y_step;
    logic signed [12:0]  w_y_look;

    player_btn_sync u_sync_jump (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_jump),
        .level (w_jump_lvl_unused),
        .rise  (w_jump_rise)
    );

    // Latched jump request; every frame either consumes or discards it.
    always_ff @(posedge clk) begin
        if (rst || frame_tick) begin
            r_jump_req <= 1'b0;
        end else if (w_jump_rise) begin
            r_jump_req <= 1'b1;
        end
    end

    // An edge arriving on the tick cycle itself still counts for that frame.
    assign w_jump_go = r_jump_req | w_jump_rise;

    assign w_vy_grav = r_vy + 8'sd1;
    assign w_y_step  = {r_y[11], r_y} + {{5{r_vy[7]}}, r_vy};
    // Landing looks one frame ahead: touch down as soon as the next move
    // (post-gravity speed) would reach or cross the ground line.
    assign w_y_look  = w_y_step + {{5{w_vy_grav[7]}}, w_vy_grav};

    // Jump FSM: take off from GROUND, integrate position and gravity in AIR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_jump <= GROUND;
            r_y    <= '0;
            r_vy   <= '0;
        end else if (frame_tick) begin
            case (r_jump)
                GROUND: begin
                    if (w_jump_go) begin
                        r_jump <= AIR;
                        r_y    <= c_y_takeoff;
                        r_vy   <= c_vy_takeoff;
                    end
                end
                AIR: begin
                    if (!w_y_look[12]) begin
                        r_jump <= GROUND;
                        r_y    <= '0;
                        r_vy   <= '0;
                    end else begin
                        r_y  <= w_y_step[11:0];
                        r_vy <= w_vy_grav;
                    end
                end
                default: begin
                    r_jump <= GROUND;
                    r_y    <= '0;
                    r_vy   <= '0;
                end
            endcase
        end
    end

    assign ypos_player2 = r_y;
`else
    logic w_jump_unused;

    assign w_jump_unused = btn_jump;
    assign ypos_player2  = 12'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_player2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player2_ctrl
// Description : Self-checking bench for player2_ctrl. Directed scenarios plus
//               randomized button segments against a frame-level model.
//               Honors PLAYER2_JUMP_EN for the vertical expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player2_ctrl;
    import state_pkg::*;

    localparam int X0   = 600;
    localparam int XMAX = 984;
    localparam int STP  = 4;
    localparam int ANIM = 8;
    localparam int V0   = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [11:0] x0, y0, xw, yw;
    state_t      s0, sw;

    int total = 0;
    int bad   = 0;

    // Reference model state, frame granularity.
    int m_x, m_dir, m_n, m_k;
    bit m_air, m_req, m_jlvl;

    always #5 clk = ~clk;

    player2_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .xpos_player2(x0), .ypos_player2(y0), .state(s0)
    );

    player2_ctrl #(.X_INIT(982)) dut_wall (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .xpos_player2(xw), .ypos_player2(yw), .state(sw)
    );

    // Height k frames after takeoff: sum of speeds -V0, -V0+1, ...
    function automatic int air_y(input int k);
        if (k >= 2 * V0) return 0;
        return (k * (k - 1)) / 2 - V0 * k;
    endfunction

    // Pose after n consecutive frames walking in direction dir (1=R, 2=L).
    function automatic state_t exp_pose(input int dir, input int n);
        int ph;
        ph = ((n - 1) / ANIM) % 2;
        if (dir == 1) return (ph == 0) ? RIGHT1 : RIGHT2;
        if (dir == 2) return (ph == 0) ? LEFT1 : LEFT2;
        return IDLE;
    endfunction

    function automatic logic [11:0] exp_y();
        int y;
        y = 0;
`ifdef PLAYER2_JUMP_EN
        if (m_air) y = air_y(m_k);
`endif
        return 12'(y);
    endfunction

    task automatic model_reset();
        m_x = X0; m_dir = 0; m_n = 0; m_k = 0;
        m_air = 0; m_req = 0; m_jlvl = 0;
    endtask

    task automatic model_buttons(input bit j);
        if (j && !m_jlvl) m_req = 1;
        m_jlvl = j;
    endtask

    task automatic model_frame(input bit l, input bit r);
        int dir;
        dir = (l && !r) ? 2 : (r && !l) ? 1 : 0;
        if (dir != m_dir) m_n = (dir != 0) ? 1 : 0;
        else if (dir != 0) m_n = m_n + 1;
        m_dir = dir;
        if (dir == 1) m_x = (m_x + STP > XMAX) ? XMAX : m_x + STP;
        if (dir == 2) m_x = (m_x - STP < 0) ? 0 : m_x - STP;
`ifdef PLAYER2_JUMP_EN
        if (m_air) begin
            m_k = m_k + 1;
            if (m_k >= 2 * V0) m_air = 0;
        end else if (m_req) begin
            m_air = 1;
            m_k = 1;
        end
`endif
        m_req = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic settle_btns(input logic l, input logic r, input logic j);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_jump = j;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame();
        repeat (2) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        total++;
        if (x0 !== 12'd600 || y0 !== 12'd0 || s0 !== IDLE) begin
            bad++;
            $display("FAIL reset_state: x=%0d y=%0d st=%0d, want x=600 y=0 st=IDLE", x0, y0, s0);
        end
        for (int f = 1; f <= 3; f++) begin
            frame();
            total++;
            if (x0 !== 12'd600 || y0 !== 12'd0 || s0 !== IDLE) begin
                bad++;
                $display("FAIL idle_frame%0d: x=%0d y=%0d st=%0d, want x=600 y=0 st=IDLE", f, x0, y0, s0);
            end
        end
    endtask

    task automatic test_walk_right();
        state_t es;
        reset_dut();
        settle_btns(1'b0, 1'b1, 1'b0);
        for (int f = 1; f <= 16; f++) begin
            frame();
            es = (f <= 8) ? RIGHT1 : RIGHT2;
            total++;
            if (x0 !== 12'(600 + 4 * f) || s0 !== es) begin
                bad++;
                $display("FAIL walk_right_f%0d: x=%0d st=%0d, want x=%0d st=%0d", f, x0, s0, 600 + 4 * f, es);
            end
        end
        // Hold still for a few cycles without a tick: nothing may move.
        repeat (5) @(negedge clk);
        total++;
        if (x0 !== 12'd664 || s0 !== RIGHT2) begin
            bad++;
            $display("FAIL hold_no_tick: x=%0d st=%0d, want x=664 st=RIGHT2", x0, s0);
        end
        // Reverse direction: restart at phase 1 of the new direction.
        settle_btns(1'b1, 1'b0, 1'b0);
        frame();
        total++;
        if (x0 !== 12'd660 || s0 !== LEFT1) begin
            bad++;
            $display("FAIL reverse: x=%0d st=%0d, want x=660 st=LEFT1", x0, s0);
        end
    endtask

    task automatic test_walls();
        int ex;
        reset_dut();
        settle_btns(1'b0, 1'b1, 1'b0);
        for (int f = 1; f <= 2; f++) begin
            frame();
            total++;
            if (xw !== 12'd984 || sw !== RIGHT1) begin
                bad++;
                $display("FAIL right_wall_f%0d: x=%0d st=%0d, want x=984 st=RIGHT1", f, xw, sw);
            end
        end
        reset_dut();
        settle_btns(1'b1, 1'b0, 1'b0);
        for (int f = 1; f <= 156; f++) begin
            frame();
            ex = (600 - 4 * f < 0) ? 0 : 600 - 4 * f;
            total++;
            if (x0 !== 12'(ex) || s0 !== exp_pose(2, f)) begin
                bad++;
                $display("FAIL left_wall_f%0d: x=%0d st=%0d, want x=%0d st=%0d", f, x0, s0, ex, exp_pose(2, f));
            end
        end
    endtask

    task automatic test_both();
        reset_dut();
        settle_btns(1'b0, 1'b1, 1'b0);
        repeat (3) frame();
        settle_btns(1'b1, 1'b1, 1'b0);
        for (int f = 1; f <= 5; f++) begin
            frame();
            total++;
            if (x0 !== 12'd612 || s0 !== IDLE) begin
                bad++;
                $display("FAIL both_btn_f%0d: x=%0d st=%0d, want x=612 st=IDLE", f, x0, s0);
            end
        end
    endtask

    task automatic test_jump();
        logic [11:0] ey;
        int          peak;
        reset_dut();
        settle_btns(1'b0, 1'b0, 1'b1);
        settle_btns(1'b0, 1'b0, 1'b0);
        peak = 0;
        for (int k = 1; k <= 27; k++) begin
            if (k == 5) begin
                settle_btns(1'b0, 1'b0, 1'b1);
                settle_btns(1'b0, 1'b0, 1'b0);
            end
            frame();
`ifdef PLAYER2_JUMP_EN
            ey = 12'(air_y(k));
`else
            ey = 12'd0;
`endif
            if ($signed(y0) < peak) peak = $signed(y0);
            total++;
            if (y0 !== ey || s0 !== IDLE || x0 !== 12'd600) begin
                bad++;
                $display("FAIL jump_f%0d: y=%0d x=%0d st=%0d, want y=%0d x=600 st=IDLE", k, $signed(y0), x0, s0, $signed(ey));
            end
        end
        total++;
`ifdef PLAYER2_JUMP_EN
        if (peak != -78) begin
`else
        if (peak != 0) begin
`endif
            bad++;
            $display("FAIL jump_peak: got %0d", peak);
        end
    endtask

    task automatic test_reset_mid_jump();
        reset_dut();
        settle_btns(1'b0, 1'b0, 1'b1);
        settle_btns(1'b0, 1'b0, 1'b0);
        settle_btns(1'b0, 1'b1, 1'b0);
        repeat (4) frame();
        total++;
`ifdef PLAYER2_JUMP_EN
        if (y0 !== 12'(-42) || x0 !== 12'd616) begin
`else
        if (y0 !== 12'd0 || x0 !== 12'd616) begin
`endif
            bad++;
            $display("FAIL pre_reset_air: y=%0d x=%0d", $signed(y0), x0);
        end
        rst = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        total++;
        if (y0 !== 12'd0 || s0 !== IDLE || x0 !== 12'd600) begin
            bad++;
            $display("FAIL reset_mid_jump: y=%0d x=%0d st=%0d, want y=0 x=600 st=IDLE", $signed(y0), x0, s0);
        end
        rst = 1'b0; frame_tick = 1'b0; btn_right = 1'b0;
        repeat (4) @(negedge clk);
        frame();
        total++;
        if (y0 !== 12'd0 || s0 !== IDLE || x0 !== 12'd600) begin
            bad++;
            $display("FAIL after_reset_frame: y=%0d x=%0d st=%0d, want y=0 x=600 st=IDLE", $signed(y0), x0, s0);
        end
    endtask

    task automatic test_random();
        bit l, r, j;
        int len;
        reset_dut();
        for (int seg = 0; seg < 45; seg++) begin
            {l, r} = 2'($urandom_range(0, 3));
            j = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 12);
            model_buttons(j);
            settle_btns(l, r, j);
            for (int f = 0; f < len; f++) begin
                frame();
                model_frame(l, r);
                total++;
                if (x0 !== 12'(m_x) || y0 !== exp_y() || s0 !== exp_pose(m_dir, m_n)) begin
                    bad++;
                    $display("FAIL random_s%0d_f%0d: x=%0d y=%0d st=%0d, want x=%0d y=%0d st=%0d",
                             seg, f, x0, $signed(y0), s0, m_x, $signed(exp_y()), exp_pose(m_dir, m_n));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk_right();
        test_walls();
        test_both();
        test_jump();
        test_reset_mid_jump();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
